// File: rtl/ripemd160_feeder.sv
// Byte-stream front end for a RIPEMD-160 core: packs up to MAX_BYTES bytes, starts the
// core, waits for its done edge (or times out), and hands the digest downstream.
module ripemd160_feeder #(
  parameter int TIMEOUT   = 1023,
  parameter int MAX_BYTES = 55
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  input  logic                     byte_last,
  output logic                     byte_ready,
  output logic [8*MAX_BYTES-1:0]   message,
  output logic                     valid_in,
  input  logic                     valid_out,
  input  logic [159:0]             Hash_result,
  output logic [159:0]             hash_out,
  output logic                     hash_valid,
  input  logic                     hash_ready,
  output logic [1:0]               err,
  output logic [5:0]               msg_len
);

  localparam int MSG_W  = 8 * MAX_BYTES;
  localparam int WAIT_W = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_HASH    = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_OVF = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

  localparam logic [5:0]        MAX_LEN   = 6'(MAX_BYTES);
  // The counter starts at 0 on HASH entry, so TIMEOUT HASH cycles end at TIMEOUT-1.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [MSG_W-1:0]  message_q, message_d;
  logic [5:0]        msg_len_q, msg_len_d;
  logic              overflow_q, overflow_d;
  logic              valid_in_q, valid_in_d;
  logic [159:0]      hash_out_q, hash_out_d;
  logic              hash_valid_q, hash_valid_d;
  logic [1:0]        err_q, err_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              valid_out_q;

  logic byte_fire;
  logic vo_rise;

  assign byte_fire = byte_valid & byte_ready;
  // Only a fresh rising edge counts; a core still holding done from an earlier job is ignored.
  assign vo_rise   = valid_out & ~valid_out_q;

  always_comb begin
    state_d      = state_q;
    message_d    = message_q;
    msg_len_d    = msg_len_q;
    overflow_d   = overflow_q;
    valid_in_d   = valid_in_q;
    hash_out_d   = hash_out_q;
    hash_valid_d = hash_valid_q;
    err_d        = err_q;
    wait_cnt_d   = wait_cnt_q;

    case (state_q)
      S_COLLECT: begin
        if (byte_fire) begin
          if (msg_len_q < MAX_LEN) begin
            message_d = {message_q[MSG_W-9:0], byte_data};
            msg_len_d = msg_len_q + 6'd1;
          end else begin
            overflow_d = 1'b1;
          end
          if (byte_last) begin
            if (overflow_d) begin
              state_d      = S_DONE;
              err_d        = ERR_OVF;
              hash_out_d   = '0;
              hash_valid_d = 1'b1;
            end else begin
              state_d    = S_HASH;
              valid_in_d = 1'b1;
              wait_cnt_d = '0;
            end
          end
        end
      end

      S_HASH: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (vo_rise) begin
          state_d      = S_DONE;
          valid_in_d   = 1'b0;
          hash_out_d   = Hash_result;
          err_d        = ERR_OK;
          hash_valid_d = 1'b1;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d      = S_DONE;
          valid_in_d   = 1'b0;
          hash_out_d   = '0;
          err_d        = ERR_TMO;
          hash_valid_d = 1'b1;
        end
      end

      S_DONE: begin
        if (hash_ready) begin
          state_d      = S_COLLECT;
          message_d    = '0;
          msg_len_d    = '0;
          overflow_d   = 1'b0;
          hash_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = S_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_COLLECT;
      message_q    <= '0;
      msg_len_q    <= '0;
      overflow_q   <= 1'b0;
      valid_in_q   <= 1'b0;
      hash_out_q   <= '0;
      hash_valid_q <= 1'b0;
      err_q        <= ERR_OK;
      wait_cnt_q   <= '0;
      valid_out_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      message_q    <= message_d;
      msg_len_q    <= msg_len_d;
      overflow_q   <= overflow_d;
      valid_in_q   <= valid_in_d;
      hash_out_q   <= hash_out_d;
      hash_valid_q <= hash_valid_d;
      err_q        <= err_d;
      wait_cnt_q   <= wait_cnt_d;
      valid_out_q  <= valid_out;
    end
  end

  assign byte_ready = (state_q == S_COLLECT);
  assign message    = message_q;
  assign msg_len    = msg_len_q;
  assign valid_in   = valid_in_q;
  assign hash_out   = hash_out_q;
  assign hash_valid = hash_valid_q;
  assign err        = err_q;

endmodule
